// File: rtl/retire_trace_checker.sv
// rtl/retire_trace_checker.sv - multi-lane golden-trace retire comparator with buffered golden records
module retire_trace_checker #(
    parameter int          RETIRE_LANES = 1,
    parameter int          FIFO_DEPTH   = 16,
    parameter logic [31:0] END_ADDR     = 32'h0C,
    parameter int          TIMEOUT      = 1000000
) (
    input  logic                         sys_clk,
    input  logic                         sys_reset_n,
    input  logic                         gold_valid,
    output logic                         gold_ready,
    input  logic [31:0]                  gold_pc,
    input  logic [4:0]                   gold_waddr,
    input  logic [31:0]                  gold_wdata,
    input  logic [31:0]                  gold_mask,
    input  logic                         gold_last,
    input  logic [RETIRE_LANES-1:0]      rt_valid,
    input  logic [RETIRE_LANES-1:0]      rt_wen,
    input  logic [32*RETIRE_LANES-1:0]   rt_pc,
    input  logic [5*RETIRE_LANES-1:0]    rt_waddr,
    input  logic [32*RETIRE_LANES-1:0]   rt_wdata,
    input  logic                         mem_wen,
    input  logic [31:0]                  mem_addr,
    input  logic [31:0]                  mem_wdata,
    output logic [31:0]                  cmp_count,
    output logic                         pass,
    output logic                         fail,
    output logic [2:0]                   err_cause,
    output logic [31:0]                  err_pc,
    output logic [4:0]                   err_waddr,
    output logic [31:0]                  err_wdata,
    output logic [31:0]                  err_gold_pc
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [31:0] TO_LAST = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

    localparam logic [2:0] CAUSE_NONE     = 3'd0;
    localparam logic [2:0] CAUSE_MISMATCH = 3'd1;
    localparam logic [2:0] CAUSE_UNDER    = 3'd2;
    localparam logic [2:0] CAUSE_EARLY    = 3'd3;
    localparam logic [2:0] CAUSE_TIMEOUT  = 3'd4;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PASS = 2'd1,
        ST_FAIL = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [31:0] r_fifo_pc    [FIFO_DEPTH];
    logic [4:0]  r_fifo_waddr [FIFO_DEPTH];
    logic [31:0] r_fifo_wdata [FIFO_DEPTH];
    logic [31:0] r_fifo_mask  [FIFO_DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          r_trace_done;
    logic [31:0]   r_timer;

    logic [31:0] r_cmp_count;
    logic [2:0]  r_err_cause;
    logic [31:0] r_err_pc;
    logic [4:0]  r_err_waddr;
    logic [31:0] r_err_wdata;
    logic [31:0] r_err_gold_pc;

    logic                    w_run;
    logic                    w_accept;
    logic                    w_push;
    logic [RETIRE_LANES-1:0] w_active;
    logic [CW-1:0]           w_n_active;
    logic [AW-1:0]           w_idx;
    logic                    w_cmp_fail;
    logic [2:0]              w_fail_cause;
    logic [31:0]             w_fail_pc;
    logic [4:0]              w_fail_waddr;
    logic [31:0]             w_fail_wdata;
    logic [31:0]             w_fail_gold_pc;
    logic                    w_end;
    logic                    w_timeout;
    logic [2:0]              w_cause_nxt;

    assign w_run      = (r_state == ST_RUN);
    assign gold_ready = w_run && (r_count != CW'(FIFO_DEPTH));
    assign w_accept   = gold_valid && gold_ready;
    assign w_push     = w_accept && (gold_waddr != 5'd0);
    assign w_end      = mem_wen && (mem_addr == END_ADDR) && (mem_wdata == 32'd0);
    assign w_timeout  = (TIMEOUT != 0) && (w_n_active == '0) && (r_timer == TO_LAST);

    // Walk lanes oldest first; each active lane claims the next FIFO head, first failure wins.
    always_comb begin
        w_active       = '0;
        w_n_active     = '0;
        w_idx          = '0;
        w_cmp_fail     = 1'b0;
        w_fail_cause   = CAUSE_NONE;
        w_fail_pc      = 32'd0;
        w_fail_waddr   = 5'd0;
        w_fail_wdata   = 32'd0;
        w_fail_gold_pc = 32'd0;
        for (int i = 0; i < RETIRE_LANES; i++) begin
            w_active[i] = rt_valid[i] && rt_wen[i] && (rt_waddr[5*i +: 5] != 5'd0);
            if (w_active[i] && !w_cmp_fail) begin
                w_idx = r_rd_ptr + w_n_active[AW-1:0];
                if (w_n_active >= r_count) begin
                    w_cmp_fail     = 1'b1;
                    w_fail_cause   = CAUSE_UNDER;
                    w_fail_pc      = rt_pc[32*i +: 32];
                    w_fail_waddr   = rt_waddr[5*i +: 5];
                    w_fail_wdata   = rt_wdata[32*i +: 32];
                    w_fail_gold_pc = 32'd0;
                end else if ((rt_pc[32*i +: 32] != r_fifo_pc[w_idx]) ||
                             (rt_waddr[5*i +: 5] != r_fifo_waddr[w_idx]) ||
                             (((rt_wdata[32*i +: 32] ^ r_fifo_wdata[w_idx]) & r_fifo_mask[w_idx]) != 32'd0)) begin
                    w_cmp_fail     = 1'b1;
                    w_fail_cause   = CAUSE_MISMATCH;
                    w_fail_pc      = rt_pc[32*i +: 32];
                    w_fail_waddr   = rt_waddr[5*i +: 5];
                    w_fail_wdata   = rt_wdata[32*i +: 32];
                    w_fail_gold_pc = r_fifo_pc[w_idx];
                end
            end
            if (w_active[i]) begin
                w_n_active = w_n_active + CW'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cause_nxt = CAUSE_NONE;
        case (r_state)
            ST_RUN: begin
                if (w_cmp_fail) begin
                    w_state_nxt = ST_FAIL;
                    w_cause_nxt = w_fail_cause;
                end else if (w_end) begin
                    if (r_trace_done && (r_count == '0) && (w_n_active == '0)) begin
                        w_state_nxt = ST_PASS;
                    end else begin
                        w_state_nxt = ST_FAIL;
                        w_cause_nxt = CAUSE_EARLY;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = ST_FAIL;
                    w_cause_nxt = CAUSE_TIMEOUT;
                end
            end
            ST_PASS: w_state_nxt = ST_PASS;
            ST_FAIL: w_state_nxt = ST_FAIL;
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (w_push) begin
            r_fifo_pc[r_wr_ptr]    <= gold_pc;
            r_fifo_waddr[r_wr_ptr] <= gold_waddr;
            r_fifo_wdata[r_wr_ptr] <= gold_wdata;
            r_fifo_mask[r_wr_ptr]  <= gold_mask;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_reset_n) begin
            r_state       <= ST_RUN;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_trace_done  <= 1'b0;
            r_timer       <= 32'd0;
            r_cmp_count   <= 32'd0;
            r_err_cause   <= CAUSE_NONE;
            r_err_pc      <= 32'd0;
            r_err_waddr   <= 5'd0;
            r_err_wdata   <= 32'd0;
            r_err_gold_pc <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_run) begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                end
                if (w_accept && gold_last) begin
                    r_trace_done <= 1'b1;
                end
                if (!w_cmp_fail) begin
                    r_rd_ptr    <= r_rd_ptr + w_n_active[AW-1:0];
                    r_count     <= r_count + CW'(w_push) - w_n_active;
                    r_cmp_count <= r_cmp_count + 32'(w_n_active);
                end
                r_timer <= (w_n_active != '0) ? 32'd0 : r_timer + 32'd1;
                if (w_state_nxt == ST_FAIL) begin
                    r_err_cause <= w_cause_nxt;
                    if (w_cmp_fail) begin
                        r_err_pc      <= w_fail_pc;
                        r_err_waddr   <= w_fail_waddr;
                        r_err_wdata   <= w_fail_wdata;
                        r_err_gold_pc <= w_fail_gold_pc;
                    end
                end
            end
        end
    end

    assign cmp_count   = r_cmp_count;
    assign pass        = (r_state == ST_PASS);
    assign fail        = (r_state == ST_FAIL);
    assign err_cause   = r_err_cause;
    assign err_pc      = r_err_pc;
    assign err_waddr   = r_err_waddr;
    assign err_wdata   = r_err_wdata;
    assign err_gold_pc = r_err_gold_pc;

endmodule

// File: tb/tb_retire_trace_checker.sv
// tb/tb_retire_trace_checker.sv - directed self-checking bench for retire_trace_checker
module tb_retire_trace_checker;

    logic        clk;
    logic        rst_n;
    logic        gold_valid;
    logic        gold_ready;
    logic [31:0] gold_pc;
    logic [4:0]  gold_waddr;
    logic [31:0] gold_wdata;
    logic [31:0] gold_mask;
    logic        gold_last;
    logic [1:0]  rt_valid;
    logic [1:0]  rt_wen;
    logic [63:0] rt_pc;
    logic [9:0]  rt_waddr;
    logic [63:0] rt_wdata;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] cmp_count;
    logic        pass;
    logic        fail;
    logic [2:0]  err_cause;
    logic [31:0] err_pc;
    logic [4:0]  err_waddr;
    logic [31:0] err_wdata;
    logic [31:0] err_gold_pc;

    logic        to_gold_ready;
    logic [31:0] to_cmp_count;
    logic        to_pass;
    logic        to_fail;
    logic [2:0]  to_err_cause;
    logic [31:0] to_err_pc;
    logic [4:0]  to_err_waddr;
    logic [31:0] to_err_wdata;
    logic [31:0] to_err_gold_pc;

    int total = 0;
    int bad   = 0;

    retire_trace_checker #(
        .RETIRE_LANES(2), .FIFO_DEPTH(16), .END_ADDR(32'h0C), .TIMEOUT(1000000)
    ) u_dut (
        .sys_clk(clk), .sys_reset_n(rst_n),
        .gold_valid(gold_valid), .gold_ready(gold_ready), .gold_pc(gold_pc),
        .gold_waddr(gold_waddr), .gold_wdata(gold_wdata), .gold_mask(gold_mask),
        .gold_last(gold_last),
        .rt_valid(rt_valid), .rt_wen(rt_wen), .rt_pc(rt_pc), .rt_waddr(rt_waddr),
        .rt_wdata(rt_wdata),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cmp_count(cmp_count), .pass(pass), .fail(fail), .err_cause(err_cause),
        .err_pc(err_pc), .err_waddr(err_waddr), .err_wdata(err_wdata),
        .err_gold_pc(err_gold_pc)
    );

    retire_trace_checker #(
        .RETIRE_LANES(1), .FIFO_DEPTH(4), .END_ADDR(32'h0C), .TIMEOUT(8)
    ) u_to (
        .sys_clk(clk), .sys_reset_n(rst_n),
        .gold_valid(1'b0), .gold_ready(to_gold_ready), .gold_pc(32'd0),
        .gold_waddr(5'd0), .gold_wdata(32'd0), .gold_mask(32'd0), .gold_last(1'b0),
        .rt_valid(1'b0), .rt_wen(1'b0), .rt_pc(32'd0), .rt_waddr(5'd0),
        .rt_wdata(32'd0),
        .mem_wen(1'b0), .mem_addr(32'd0), .mem_wdata(32'd0),
        .cmp_count(to_cmp_count), .pass(to_pass), .fail(to_fail),
        .err_cause(to_err_cause), .err_pc(to_err_pc), .err_waddr(to_err_waddr),
        .err_wdata(to_err_wdata), .err_gold_pc(to_err_gold_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        gold_valid = 1'b0; gold_pc = '0; gold_waddr = '0; gold_wdata = '0;
        gold_mask = '0; gold_last = 1'b0;
        rt_valid = '0; rt_wen = '0; rt_pc = '0; rt_waddr = '0; rt_wdata = '0;
        mem_wen = 1'b0; mem_addr = '0; mem_wdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [4:0] wa,
                        input logic [31:0] wd, input logic [31:0] mk, input logic last);
        int n;
        gold_valid = 1'b1; gold_pc = pc; gold_waddr = wa; gold_wdata = wd;
        gold_mask = mk; gold_last = last;
        n = 0;
        while (!gold_ready && n < 50) begin
            tick();
            n++;
        end
        if (!gold_ready) chk("push_ready_wait", {63'd0, gold_ready}, 64'd1);
        tick();
        gold_valid = 1'b0; gold_last = 1'b0;
    endtask

    task automatic retire0(input logic [31:0] pc, input logic [4:0] wa, input logic [31:0] wd);
        rt_valid = 2'b01; rt_wen = 2'b01;
        rt_pc = {32'd0, pc}; rt_waddr = {5'd0, wa}; rt_wdata = {32'd0, wd};
        tick();
        rt_valid = '0; rt_wen = '0;
    endtask

    task automatic retire2(input logic [31:0] pc0, input logic [4:0] wa0, input logic [31:0] wd0,
                           input logic [31:0] pc1, input logic [4:0] wa1, input logic [31:0] wd1);
        rt_valid = 2'b11; rt_wen = 2'b11;
        rt_pc = {pc1, pc0}; rt_waddr = {wa1, wa0}; rt_wdata = {wd1, wd0};
        tick();
        rt_valid = '0; rt_wen = '0;
    endtask

    task automatic end_store();
        mem_wen = 1'b1; mem_addr = 32'h0C; mem_wdata = 32'd0;
        tick();
        mem_wen = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        do_reset();

        chk("rst_gold_ready", {63'd0, gold_ready}, 64'd1);
        chk("rst_cmp_count", {32'd0, cmp_count}, 64'd0);
        chk("rst_pass", {63'd0, pass}, 64'd0);
        chk("rst_fail", {63'd0, fail}, 64'd0);
        chk("rst_err_cause", {61'd0, err_cause}, 64'd0);

        // Timeout instance: 7 idle cycles are fine, the 8th trips it.
        for (int i = 0; i < 7; i++) tick();
        chk("to_before", {63'd0, to_fail}, 64'd0);
        tick();
        chk("to_fail", {63'd0, to_fail}, 64'd1);
        chk("to_cause", {61'd0, to_err_cause}, 64'd4);
        chk("to_gold_ready", {63'd0, to_gold_ready}, 64'd0);

        // Single-lane in-order pass
        do_reset();
        push(32'h0, 5'd1, 32'h11, 32'hFFFFFFFF, 1'b0);
        push(32'h4, 5'd2, 32'h22, 32'hFFFFFFFF, 1'b0);
        push(32'h8, 5'd3, 32'h33, 32'hFFFFFFFF, 1'b1);
        retire0(32'h0, 5'd1, 32'h11);
        retire0(32'h4, 5'd2, 32'h22);
        retire0(32'h8, 5'd3, 32'h33);
        chk("inord_count", {32'd0, cmp_count}, 64'd3);
        chk("inord_fail", {63'd0, fail}, 64'd0);
        chk("inord_pass_before", {63'd0, pass}, 64'd0);
        end_store();
        chk("inord_pass", {63'd0, pass}, 64'd1);
        chk("inord_ready_pass", {63'd0, gold_ready}, 64'd0);

        // Mask compare then mismatch
        do_reset();
        push(32'h100, 5'd5, 32'h1234FFFF, 32'hFFFF0000, 1'b0);
        push(32'h104, 5'd6, 32'h1234FFFF, 32'hFFFF0000, 1'b0);
        retire0(32'h100, 5'd5, 32'h12340000);
        chk("mask_count", {32'd0, cmp_count}, 64'd1);
        chk("mask_nofail", {63'd0, fail}, 64'd0);
        retire0(32'h104, 5'd6, 32'h12350000);
        chk("mm_fail", {63'd0, fail}, 64'd1);
        chk("mm_cause", {61'd0, err_cause}, 64'd1);
        chk("mm_wdata", {32'd0, err_wdata}, 64'h12350000);
        chk("mm_pc", {32'd0, err_pc}, 64'h104);
        chk("mm_waddr", {59'd0, err_waddr}, 64'd6);
        chk("mm_gold_pc", {32'd0, err_gold_pc}, 64'h104);
        chk("mm_count", {32'd0, cmp_count}, 64'd1);

        // Reset mid-run clears sticky state
        do_reset();
        chk("rr_fail", {63'd0, fail}, 64'd0);
        chk("rr_cause", {61'd0, err_cause}, 64'd0);
        chk("rr_wdata", {32'd0, err_wdata}, 64'd0);
        chk("rr_count", {32'd0, cmp_count}, 64'd0);
        chk("rr_ready", {63'd0, gold_ready}, 64'd1);

        // Dual-lane: lane1 underflows
        push(32'h200, 5'd1, 32'hA, 32'hFFFFFFFF, 1'b0);
        retire2(32'h200, 5'd1, 32'hA, 32'h204, 5'd2, 32'hB);
        chk("uf_fail", {63'd0, fail}, 64'd1);
        chk("uf_cause", {61'd0, err_cause}, 64'd2);
        chk("uf_pc", {32'd0, err_pc}, 64'h204);
        chk("uf_gold_pc", {32'd0, err_gold_pc}, 64'd0);
        chk("uf_count", {32'd0, cmp_count}, 64'd0);

        // Dual-lane: lane0 mismatch beats lane1 underflow
        do_reset();
        push(32'h200, 5'd1, 32'hA, 32'hFFFFFFFF, 1'b0);
        retire2(32'h300, 5'd1, 32'hA, 32'h204, 5'd2, 32'hB);
        chk("mmuf_cause", {61'd0, err_cause}, 64'd1);
        chk("mmuf_pc", {32'd0, err_pc}, 64'h300);
        chk("mmuf_gold_pc", {32'd0, err_gold_pc}, 64'h200);

        // Zero-register filtering and lane ordering
        do_reset();
        push(32'h10, 5'd0, 32'hDEAD, 32'hFFFFFFFF, 1'b0);
        push(32'h14, 5'd4, 32'hAB, 32'hFFFFFFFF, 1'b0);
        push(32'h18, 5'd7, 32'hCD, 32'hFFFFFFFF, 1'b1);
        retire2(32'h10, 5'd0, 32'hDEAD, 32'h14, 5'd4, 32'hAB);
        chk("zf_count1", {32'd0, cmp_count}, 64'd1);
        chk("zf_fail1", {63'd0, fail}, 64'd0);
        retire0(32'h18, 5'd7, 32'hCD);
        chk("zf_count2", {32'd0, cmp_count}, 64'd2);
        end_store();
        chk("zf_pass", {63'd0, pass}, 64'd1);

        // Backpressure: fill, drain one, refill, drain all
        do_reset();
        for (int i = 0; i < 16; i++)
            push(32'h1000 + 32'(4*i), 5'(i+1), 32'(i), 32'hFFFFFFFF, 1'b0);
        chk("bp_full_ready", {63'd0, gold_ready}, 64'd0);
        retire0(32'h1000, 5'd1, 32'd0);
        chk("bp_ready_again", {63'd0, gold_ready}, 64'd1);
        push(32'h1040, 5'd17, 32'd16, 32'hFFFFFFFF, 1'b1);
        for (int i = 1; i < 17; i += 2)
            retire2(32'h1000 + 32'(4*i), 5'(i+1), 32'(i),
                    32'h1000 + 32'(4*(i+1)), 5'(i+2), 32'(i+1));
        chk("bp_count", {32'd0, cmp_count}, 64'd17);
        chk("bp_fail", {63'd0, fail}, 64'd0);
        end_store();
        chk("bp_pass", {63'd0, pass}, 64'd1);

        // Early end with records pending
        do_reset();
        push(32'h20, 5'd1, 32'h1, 32'hFFFFFFFF, 1'b0);
        push(32'h24, 5'd2, 32'h2, 32'hFFFFFFFF, 1'b1);
        end_store();
        chk("ee_fail", {63'd0, fail}, 64'd1);
        chk("ee_cause", {61'd0, err_cause}, 64'd3);
        chk("ee_pass", {63'd0, pass}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/retire_trace_checker.md
Name: retire_trace_checker

Overview:
- Synthesizable, multi-lane successor to the simulation-only golden-trace comparator.
- Buffers golden register-write records from a streaming source in a FIFO.
- Compares them in program order against up to RETIRE_LANES retired instructions per cycle.
- Flags the first mismatch, underflow, early end or timeout. Detects benchmark pass on the end-of-test store.
- Sits beside the CPU on FPGA or in simulation, fed by a trace loader or DMA stream.

Parameters:
- RETIRE_LANES, 1, retire events per cycle (1 or 2); lane 0 is older.
- FIFO_DEPTH, 16, golden record buffer entries (power of 2, >=4).
- END_ADDR, 32'h0C, store address that signals end of test.
- TIMEOUT, 1000000, cycles in RUN with no compare before timeout failure (0 disables).

Ports:
- sys_clk  in  1  clock
- sys_reset_n  in  1  synchronous active-low reset
- gold_valid  in  1  golden record valid
- gold_ready  out  1  checker can accept record
- gold_pc  in  32  golden PC
- gold_waddr  in  5  golden destination register
- gold_wdata  in  32  golden write data
- gold_mask  in  32  bit-compare mask
- gold_last  in  1  final record of trace
- rt_valid  in  RETIRE_LANES  lane retires this cycle
- rt_wen  in  RETIRE_LANES  lane writes register file
- rt_pc  in  32*RETIRE_LANES  lane PC, lane i at [32i+:32]
- rt_waddr  in  5*RETIRE_LANES  lane destination register
- rt_wdata  in  32*RETIRE_LANES  lane write data
- mem_wen  in  1  CPU store strobe
- mem_addr  in  32  store address
- mem_wdata  in  32  store data
- cmp_count  out  32  number of successful compares
- pass  out  1  sticky benchmark pass
- fail  out  1  sticky failure
- err_cause  out  3  0 none, 1 mismatch, 2 underflow, 3 early end, 4 timeout
- err_pc  out  32  retire PC at failure
- err_waddr  out  5  retire waddr at failure
- err_wdata  out  32  retire wdata at failure
- err_gold_pc  out  32  golden PC at failure

Behaviour:
- Reset (sys_reset_n=0 at a sys_clk edge):
  - FIFO emptied, state RUN, trace_done=0, timer=0.
  - All outputs 0 except gold_ready=1.
  - Reset mid-operation discards buffered records and clears sticky flags.
- Golden input:
  - A record transfers when gold_valid & gold_ready.
  - Records with gold_waddr==0 are accepted but not stored; their gold_last still counts.
  - gold_ready = (state==RUN) & FIFO not full.
  - Accepted gold_last sets trace_done.
  - No overflow is possible.
- Compare events:
  - A lane is active if rt_valid[i] & rt_wen[i] & rt_waddr!=0. Inactive lanes are ignored.
  - Active lanes consume FIFO heads in lane order: the lowest active lane takes head 0, the next takes head 1.
  - Lane i mismatches if pc != gold_pc, or waddr != gold_waddr, or (wdata & mask) != (gold_wdata & mask), using the consumed record's mask.
- Same-cycle push and pop:
  - A record pushed in cycle N is comparable no earlier than cycle N+1 (registered FIFO).
  - Full and empty are computed on pre-cycle occupancy.
- Failure priority, checked in lane order:
  - The first failing lane wins.
  - Underflow (active lane with no head available) beats mismatch for that lane.
  - The older lane's mismatch beats the younger lane's underflow.
- Result timing (1-cycle latency):
  - On the cycle after a failure, fail=1, state FAIL, err_* hold the failing lane's retire fields, err_gold_pc holds the consumed golden PC (0 on underflow).
  - On all-pass, cmp_count += number of active lanes. It wraps at 2^32.
- End detection: end strobe = mem_wen & mem_addr==END_ADDR & mem_wdata==0.
  - In RUN with trace_done & FIFO empty & no compare this cycle → PASS next cycle.
  - Otherwise → FAIL, cause 3. If a compare also fails the same cycle, the compare failure takes priority.
- Timeout:
  - The timer counts cycles in RUN without an active lane and resets on any active lane.
  - Reaching TIMEOUT → FAIL, cause 4.
- PASS and FAIL are terminal until reset: gold_ready=0, counters frozen, err_* stable.
- States: RUN → PASS | FAIL. No other transitions.

Test Plan:
- Single-lane in-order: push 3 records (pc 0x0,0x4,0x8, waddr 1,2,3), then retire matching → cmp_count=3, fail=0, then end store to 0x0C with data 0 after gold_last → pass=1 next cycle.
- Mask: golden wdata 0x1234FFFF, mask 0xFFFF0000, retire wdata 0x12340000 → match. Retire 0x12350000 → fail=1, err_cause=1, err_wdata=0x12350000.
- Dual-lane (RETIRE_LANES=2): both lanes active, one record buffered → lane1 underflow, err_cause=2, err_pc=lane1 PC, cmp_count unchanged. Repeat with lane0 mismatching too → err_cause=1, err_pc=lane0 PC.
- Zero-register filtering: golden waddr 0 record plus retire waddr 0 interleaved → neither compared, cmp_count counts only nonzero writes.
- Backpressure: push FIFO_DEPTH records with no retires → gold_ready=0. One retire → gold_ready=1 next cycle, no record lost.
- Early end / timeout: end store with 2 records pending → err_cause=3. With TIMEOUT=8 and no retires for 8 cycles → err_cause=4. Reset mid-run → all outputs cleared, gold_ready=1.
